// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and Gray/binary pointer helpers for the
//               asynchronous FIFO pointer blocks (fifo_wptr_full and
//               fifo_rptr_empty).
// Contents    : c_DEFAULT_FIFO_DEPTH / c_DEFAULT_PTR_WIDTH - default geometry
//               ptr_word_t                               - widest pointer word
//               bin2gray / gray2bin                      - code conversions
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   // Default geometry: 8 entries, one extra pointer bit to tell full from empty.
   localparam int c_DEFAULT_FIFO_DEPTH = 8;
   localparam int c_DEFAULT_PTR_WIDTH  = 4;

   // The conversion helpers work on a fixed wide word. Callers zero-extend
   // their pointer into it and size-cast the result back, so a single pair of
   // functions serves every pointer width up to this limit.
   localparam int c_MAX_PTR_WIDTH = 32;

   typedef logic [c_MAX_PTR_WIDTH-1:0] ptr_word_t;

   // Binary to reflected Gray code.
   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Reflected Gray code to binary. Each binary bit is the XOR of all Gray
   // bits at and above it; zero-extended upper bits leave the result intact.
   function automatic ptr_word_t gray2bin(input ptr_word_t gray);
      ptr_word_t bin;
      bin = gray;
      for (int i = c_MAX_PTR_WIDTH - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/data_sync.sv
`default_nettype none
// ============================================================================
// Module      : data_sync
// Description : Multi-flop synchronizer for a bus that is already safe to
//               sample bit-by-bit (e.g. a Gray-coded pointer, where at most
//               one bit changes between consecutive values).
// Parameters  : WIDTH  - bus width
//               STAGES - number of flops in the chain (2 or more)
// Ports       : clk    - destination-domain clock
//               rst    - synchronous, active-high reset; clears every stage
//               i_data - bus from the source domain (asynchronous to clk)
//               o_data - synchronized bus, STAGES clk edges behind i_data
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   // Stage 0 is the only flop that may go metastable; later stages give it
   // a full clock period each to resolve.
   logic [WIDTH-1:0] r_sync [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= i_data;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign o_data = r_sync[STAGES-1];

endmodule : data_sync
`default_nettype wire

// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wptr_full
// Description : Write-side pointer and full-flag logic of an asynchronous
//               FIFO. Keeps the binary write pointer, publishes it in Gray
//               code to the read domain, synchronizes the read domain's Gray
//               pointer and derives full, fill level and overflow from it.
// Parameters  : FIFO_DEPTH   - memory entries, power of two (4 or more)
//               PTR_WIDTH    - log2(FIFO_DEPTH)+1
//               SYNC_STAGES  - read-pointer synchronizer flops (2 or more)
//               AF_THRESHOLD - fill level at which w_almost_full asserts
// Ports       : w_clk         - write-domain clock
//               w_rst         - synchronous, active-high reset
//               w_inc         - write request for this cycle
//               r_ptr         - Gray read pointer from the read domain
//               w_addr        - binary write address into the FIFO memory
//               w_ptr         - registered Gray write pointer to read domain
//               w_full        - registered full flag / memory write gate
//               w_count       - fill level seen from the write side
//               w_ovf         - sticky: write attempted while full
//               w_almost_full - fill level >= AF_THRESHOLD (optional)
// Build macro : FIFO_WR_ALMOST_FULL_EN - adds the w_almost_full port and its
//               register; without it the port and logic are absent.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int FIFO_DEPTH   = c_DEFAULT_FIFO_DEPTH,
   parameter int PTR_WIDTH    = c_DEFAULT_PTR_WIDTH,
   parameter int SYNC_STAGES  = 2,
   parameter int AF_THRESHOLD = 6
) (
   input  logic                 w_clk,
   input  logic                 w_rst,
   input  logic                 w_inc,
   input  logic [PTR_WIDTH-1:0] r_ptr,
   output logic [PTR_WIDTH-2:0] w_addr,
   output logic [PTR_WIDTH-1:0] w_ptr,
   output logic                 w_full,
   output logic [PTR_WIDTH-1:0] w_count,
   output logic                 w_ovf
`ifdef FIFO_WR_ALMOST_FULL_EN
   ,
   output logic                 w_almost_full
`endif
);

   // -------------------------------------------------------------------------
   // Registered state
   // -------------------------------------------------------------------------
   logic [PTR_WIDTH-1:0] r_bin;         // binary write pointer
   logic [PTR_WIDTH-1:0] r_gray;        // Gray write pointer (= w_ptr)
   logic                 r_full;
   logic [PTR_WIDTH-1:0] r_count;
   logic                 r_ovf;

   // -------------------------------------------------------------------------
   // Combinational next-state terms
   // -------------------------------------------------------------------------
   logic                 w_write_ok;    // request accepted this cycle
   logic [PTR_WIDTH-1:0] w_bin_next;
   logic [PTR_WIDTH-1:0] w_gray_next;
   logic [PTR_WIDTH-1:0] w_rq_ptr;      // synchronized Gray read pointer
   logic [PTR_WIDTH-1:0] w_rq_bin;      // its binary value
   logic [PTR_WIDTH-1:0] w_full_match;  // Gray value meaning "one lap ahead"
   logic                 w_full_next;
   logic [PTR_WIDTH-1:0] w_count_next;

   // -------------------------------------------------------------------------
   // Read-pointer synchronizer: the only consumer of r_ptr.
   // -------------------------------------------------------------------------
   data_sync #(
      .WIDTH  (PTR_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk    (w_clk),
      .rst    (w_rst),
      .i_data (r_ptr),
      .o_data (w_rq_ptr)
   );

   // -------------------------------------------------------------------------
   // Pointer advance. Gating on the registered full flag makes w_full the
   // single point of truth for whether the memory write happens.
   // -------------------------------------------------------------------------
   assign w_write_ok  = w_inc & ~r_full;
   assign w_bin_next  = r_bin + {{(PTR_WIDTH-1){1'b0}}, w_write_ok};
   assign w_gray_next = PTR_WIDTH'(bin2gray(ptr_word_t'(w_bin_next)));
   assign w_rq_bin    = PTR_WIDTH'(gray2bin(ptr_word_t'(w_rq_ptr)));

   // -------------------------------------------------------------------------
   // Full detection on the *next* Gray pointer, so the write that takes the
   // last entry raises w_full on the very same edge. In Gray code "exactly
   // one lap ahead" means the two MSBs are inverted and the rest equal.
   // The comparison uses the synchronized (stale) read pointer, so full is
   // released late rather than early, which is the safe direction.
   // -------------------------------------------------------------------------
   assign w_full_match = {~w_rq_ptr[PTR_WIDTH-1:PTR_WIDTH-2],
                           w_rq_ptr[PTR_WIDTH-3:0]};
   assign w_full_next  = (w_gray_next == w_full_match);

   // Modulo subtraction of the extended pointers gives 0..FIFO_DEPTH.
   assign w_count_next = w_bin_next - w_rq_bin;

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_bin   <= '0;
         r_gray  <= '0;
         r_full  <= 1'b0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_bin   <= w_bin_next;
         r_gray  <= w_gray_next;
         r_full  <= w_full_next;
         r_count <= w_count_next;
         // Sticky until reset: any request that arrives while full is lost.
         if (w_inc && r_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

`ifdef FIFO_WR_ALMOST_FULL_EN
   // -------------------------------------------------------------------------
   // Almost-full tracks the same next fill level as w_count, so both change
   // on the same edge.
   // -------------------------------------------------------------------------
   localparam logic [PTR_WIDTH-1:0] c_AF_LEVEL = PTR_WIDTH'(AF_THRESHOLD);

   logic r_almost_full;

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_almost_full <= 1'b0;
      end else begin
         r_almost_full <= (w_count_next >= c_AF_LEVEL);
      end
   end

   assign w_almost_full = r_almost_full;
`endif

   // -------------------------------------------------------------------------
   // Outputs. w_addr comes straight from the pointer register: the write
   // accepted on an edge lands at the address visible before that edge.
   // -------------------------------------------------------------------------
   assign w_addr  = r_bin[PTR_WIDTH-2:0];
   assign w_ptr   = r_gray;
   assign w_full  = r_full;
   assign w_count = r_count;
   assign w_ovf   = r_ovf;

endmodule : fifo_wptr_full
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wptr_full
// Description : Self-checking bench for fifo_wptr_full. A behavioural model
//               of the write side predicts every output after each clock
//               edge; the prediction is queued when the stimulus is driven
//               and popped once the DUT has clocked it.
// Build macro : FIFO_WR_ALMOST_FULL_EN - also exercises w_almost_full.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wptr_full;

   localparam int c_PW = 4;
   localparam int c_SS = 2;
   localparam logic [c_PW-1:0] c_DEPTH = 4'd8;
   localparam logic [c_PW-1:0] c_AF    = 4'd6;

   logic              w_clk = 1'b0;
   logic              w_rst;
   logic              w_inc;
   logic [c_PW-1:0]   r_ptr;
   logic [c_PW-2:0]   w_addr;
   logic [c_PW-1:0]   w_ptr;
   logic              w_full;
   logic [c_PW-1:0]   w_count;
   logic              w_ovf;
`ifdef FIFO_WR_ALMOST_FULL_EN
   logic              w_almost_full;
`endif

   fifo_wptr_full #(
      .FIFO_DEPTH   (8),
      .PTR_WIDTH    (c_PW),
      .SYNC_STAGES  (c_SS),
      .AF_THRESHOLD (6)
   ) dut (
      .w_clk         (w_clk),
      .w_rst         (w_rst),
      .w_inc         (w_inc),
      .r_ptr         (r_ptr),
      .w_addr        (w_addr),
      .w_ptr         (w_ptr),
      .w_full        (w_full),
      .w_count       (w_count),
      .w_ovf         (w_ovf)
`ifdef FIFO_WR_ALMOST_FULL_EN
      ,
      .w_almost_full (w_almost_full)
`endif
   );

   always #5 w_clk = ~w_clk;

   // {w_addr, w_ptr, w_full, w_count, w_ovf, w_almost_full}
   typedef logic [13:0] snap_t;
   snap_t sb[$];
   snap_t exp_s;
   int    n_checks = 0;
   int    n_fail   = 0;

   // Model state
   logic [c_PW-1:0] m_bin, m_sync0, m_sync1, m_cnt;
   logic            m_full, m_ovf, m_af;

   function automatic logic [c_PW-1:0] b2g(input logic [c_PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [c_PW-1:0] g2b(input logic [c_PW-1:0] g);
      logic [c_PW-1:0] b;
      b[c_PW-1] = g[c_PW-1];
      for (int i = c_PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic snap_t snap();
      logic af;
`ifdef FIFO_WR_ALMOST_FULL_EN
      af = w_almost_full;
`else
      af = 1'b0;
`endif
      return {w_addr, w_ptr, w_full, w_count, w_ovf, af};
   endfunction

   // Drive one cycle, advance the model, queue its prediction, clock it.
   task automatic drive(input logic rst, input logic inc, input logic [c_PW-1:0] rp);
      logic af_vis;
      @(negedge w_clk);
      w_rst = rst;
      w_inc = inc;
      r_ptr = rp;
      if (rst) begin
         m_bin = '0; m_sync0 = '0; m_sync1 = '0; m_cnt = '0;
         m_full = 1'b0; m_ovf = 1'b0; m_af = 1'b0;
      end else begin
         m_ovf = m_ovf | (inc & m_full);
         if (inc && !m_full) m_bin = m_bin + 4'd1;
         m_cnt   = m_bin - g2b(m_sync1);
         m_full  = (m_cnt == c_DEPTH);
         m_af    = (m_cnt >= c_AF);
         m_sync1 = m_sync0;
         m_sync0 = rp;
      end
`ifdef FIFO_WR_ALMOST_FULL_EN
      af_vis = m_af;
`else
      af_vis = 1'b0;
`endif
      sb.push_back({m_bin[c_PW-2:0], b2g(m_bin), m_full, m_cnt, m_ovf, af_vis});
      @(posedge w_clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 4'h0);
         exp_s = sb.pop_front();
         n_checks++;
         if (snap() !== exp_s) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %h expected %h", i, snap(), exp_s);
         end
      end
      n_checks++;
      if (w_addr !== 3'd0 || w_ptr !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_addr_ptr: got addr=%0d ptr=%h expected 0/0", w_addr, w_ptr);
      end
   endtask

   task automatic test_fill();
      logic [c_PW-1:0] gseq [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (w_addr !== 3'(i)) begin
            n_fail++;
            $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, w_addr, i);
         end
         drive(1'b0, 1'b1, 4'h0);
         exp_s = sb.pop_front();
         n_checks++;
         if (snap() !== exp_s) begin
            n_fail++;
            $display("FAIL fill[%0d]: got %h expected %h", i, snap(), exp_s);
         end
         n_checks++;
         if (w_ptr !== gseq[i]) begin
            n_fail++;
            $display("FAIL fill_gray[%0d]: got %h expected %h", i, w_ptr, gseq[i]);
         end
      end
      n_checks++;
      if (w_full !== 1'b1 || w_count !== 4'd8) begin
         n_fail++;
         $display("FAIL fill_full: got full=%b count=%0d expected 1/8", w_full, w_count);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, (i < 3), 4'h0);
         exp_s = sb.pop_front();
         n_checks++;
         if (snap() !== exp_s) begin
            n_fail++;
            $display("FAIL overflow[%0d]: got %h expected %h", i, snap(), exp_s);
         end
         n_checks++;
         if (w_ovf !== 1'b1 || w_addr !== 3'd0 || w_ptr !== 4'hC || w_count !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow_hold[%0d]: got ovf=%b addr=%0d ptr=%h count=%0d expected 1/0/c/8",
                     i, w_ovf, w_addr, w_ptr, w_count);
         end
      end
   endtask

   task automatic test_drain();
      for (int k = 1; k <= c_SS + 1; k++) begin
         drive(1'b0, 1'b0, 4'h1);
         exp_s = sb.pop_front();
         n_checks++;
         if (snap() !== exp_s) begin
            n_fail++;
            $display("FAIL drain[%0d]: got %h expected %h", k, snap(), exp_s);
         end
         n_checks++;
         if (w_full !== (k < c_SS + 1)) begin
            n_fail++;
            $display("FAIL drain_full_edge[%0d]: got %b expected %b", k, w_full, (k < c_SS + 1));
         end
      end
      n_checks++;
      if (w_count !== 4'd7) begin
         n_fail++;
         $display("FAIL drain_count: got %0d expected 7", w_count);
      end
      drive(1'b0, 1'b1, 4'h1);
      exp_s = sb.pop_front();
      n_checks++;
      if (snap() !== exp_s || w_full !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_refill: got %h expected %h", snap(), exp_s);
      end
   endtask

   task automatic test_wrap();
      logic [c_PW-1:0] rb;
      logic [c_PW-1:0] prev;
      drive(1'b1, 1'b0, 4'h0);
      exp_s = sb.pop_front();
      n_checks++;
      if (snap() !== exp_s) begin
         n_fail++;
         $display("FAIL wrap_reset: got %h expected %h", snap(), exp_s);
      end
      rb   = '0;
      prev = w_ptr;
      for (int p = 0; p < 20; p++) begin
         for (int c = 0; c < 4; c++) begin
            if (c == 1) rb = rb + 4'd1;
            drive(1'b0, (c == 0), b2g(rb));
            exp_s = sb.pop_front();
            n_checks++;
            if (snap() !== exp_s) begin
               n_fail++;
               $display("FAIL wrap[%0d.%0d]: got %h expected %h", p, c, snap(), exp_s);
            end
            n_checks++;
            if (w_full !== 1'b0 || w_count > 4'd1 ||
                $countones(prev ^ w_ptr) != ((c == 0) ? 1 : 0)) begin
               n_fail++;
               $display("FAIL wrap_props[%0d.%0d]: got full=%b count=%0d ptr %h->%h expected 0/<=1/one-bit step",
                        p, c, w_full, w_count, prev, w_ptr);
            end
            prev = w_ptr;
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 4'h0);
      void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 4'h0);
         exp_s = sb.pop_front();
         n_checks++;
         if (snap() !== exp_s) begin
            n_fail++;
            $display("FAIL pre_reset[%0d]: got %h expected %h", i, snap(), exp_s);
         end
      end
      drive(1'b1, 1'b1, 4'h0);
      exp_s = sb.pop_front();
      n_checks++;
      if (snap() !== exp_s || snap() !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got %h expected 0", snap());
      end
   endtask

`ifdef FIFO_WR_ALMOST_FULL_EN
   task automatic test_almost_full();
      for (int i = 1; i <= 6; i++) begin
         drive(1'b0, 1'b1, 4'h0);
         exp_s = sb.pop_front();
         n_checks++;
         if (snap() !== exp_s || w_almost_full !== (i >= 6)) begin
            n_fail++;
            $display("FAIL af_rise[%0d]: got %h af=%b expected %h", i, snap(), w_almost_full, exp_s);
         end
      end
      for (int k = 1; k <= c_SS + 1; k++) begin
         drive(1'b0, 1'b0, 4'h1);
         exp_s = sb.pop_front();
         n_checks++;
         if (snap() !== exp_s || w_almost_full !== (k < c_SS + 1)) begin
            n_fail++;
            $display("FAIL af_fall[%0d]: got %h af=%b expected %h", k, snap(), w_almost_full, exp_s);
         end
      end
   endtask
`endif

   initial begin
      w_rst = 1'b1;
      w_inc = 1'b0;
      r_ptr = '0;
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_reset_mid();
`ifdef FIFO_WR_ALMOST_FULL_EN
      test_almost_full();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_fifo_wptr_full
`default_nettype wire

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: number of memory entries; power of two only.
REQ-002 SHALL have parameter PTR_WIDTH, default 4: pointer width, equal to log2(FIFO_DEPTH)+1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flop count of the read-pointer synchronizer; minimum 2.
REQ-004 SHALL have parameter AF_THRESHOLD, default 6: fill level at which w_almost_full asserts.
REQ-005 SHALL have port w_clk, input, 1: write-domain clock.
REQ-006 SHALL have port w_rst, input, 1: synchronous, active-high reset, sampled on w_clk.
REQ-007 SHALL have port w_inc, input, 1: write request for the current cycle.
REQ-008 SHALL have port r_ptr, input, PTR_WIDTH: Gray-coded read pointer from the read clock domain; asynchronous to w_clk.
REQ-009 SHALL have port w_addr, output, PTR_WIDTH-1: binary write address to the FIFO memory.
REQ-010 SHALL have port w_ptr, output, PTR_WIDTH: registered Gray-coded write pointer to the read domain.
REQ-011 SHALL have port w_full, output, 1: registered full flag; also drives the memory write gate.
REQ-012 SHALL have port w_count, output, PTR_WIDTH: fill level seen from the write side, range 0..FIFO_DEPTH.
REQ-013 SHALL have port w_ovf, output, 1: sticky flag for a write attempted while full.
REQ-014 SHALL have port w_almost_full, output, 1: present only when FIFO_WR_ALMOST_FULL_EN is defined.

Function
REQ-015 SHALL keep a PTR_WIDTH-bit binary write pointer.
- Advances by 1 on each w_clk edge with w_inc=1 and w_full=0.
- Holds otherwise.
- Wraps from 2^PTR_WIDTH-1 to 0.
REQ-016 SHALL drive w_addr from the low PTR_WIDTH-1 bits of the binary pointer, with no added latency; a write accepted at edge N uses the w_addr value present before edge N.
REQ-017 SHALL register w_ptr as the Gray code of the next binary pointer, so w_ptr changes on the same edge as the binary pointer, one bit per increment.
REQ-018 SHALL pass r_ptr through SYNC_STAGES flops clocked by w_clk, giving rq_ptr; no other logic SHALL sample r_ptr.
REQ-019 SHALL register w_full as 1 when the next Gray write pointer equals rq_ptr with its two MSBs inverted and its remaining bits equal; otherwise 0.
REQ-020 SHALL ensure that after the write that fills the last entry, w_full is 1 in the very next cycle, with no bubble.
REQ-021 SHALL deassert w_full no earlier than SYNC_STAGES+1 w_clk edges after r_ptr changes; this pessimism is intended.
REQ-022 SHALL ignore w_inc=1 while w_full=1: no pointer move and no w_ptr change.
REQ-023 SHALL set w_ovf to 1 on the cycle after any edge with w_inc=1 and w_full=1; w_ovf holds until reset.
REQ-024 SHALL register w_count as the next binary write pointer minus the binary conversion of rq_ptr, modulo 2^PTR_WIDTH; w_count SHALL equal FIFO_DEPTH exactly when w_full=1.
REQ-025 SHALL handle a write and an r_ptr change in the same cycle as independent events; the write is judged only against the already-synchronized rq_ptr.

Reset
REQ-026 SHALL, when w_rst=1 at a w_clk edge, clear all of the following to 0: binary pointer, w_ptr, synchronizer flops, w_full, w_count, w_ovf, w_almost_full.
REQ-027 SHALL give reset priority over w_inc; a write presented during reset is dropped.
REQ-028 SHALL drive w_addr=0 in the first cycle after reset release.

Configuration
REQ-029 SHALL, with FIFO_WR_ALMOST_FULL_EN defined, register w_almost_full as (next w_count >= AF_THRESHOLD).
REQ-030 SHALL, without FIFO_WR_ALMOST_FULL_EN, omit the w_almost_full port and its logic; all other behaviour is unchanged.

Structure
REQ-031 SHALL take the Gray/binary conversion functions and the default FIFO_DEPTH/PTR_WIDTH constants from the shared package fifo_pkg, which fifo_rptr_empty also uses.
REQ-032 SHALL implement the synchronizer as the sub-module data_sync (width, stages parameters), which can be reused on the read side.

Verification
REQ-033 Reset fill: w_rst 1 for 2 cycles, then w_inc=1 for 8 cycles with r_ptr=0.
- w_addr steps 0..7.
- w_ptr steps 0,1,3,2,6,7,5,4,C.
- w_full=1 after the 8th write; w_count=8.
REQ-034 Overflow: full FIFO, w_inc=1 for 3 cycles.
- w_addr, w_ptr, w_count unchanged.
- w_ovf=1 from the next cycle and stays 1 until w_rst.
REQ-035 Drain release: full FIFO, r_ptr stepped to Gray 1 (one read).
- w_full falls exactly SYNC_STAGES+1 edges later; w_count=7.
- The next write sets w_full again.
REQ-036 Wrap: 20 write/read pairs with pointers crossing 15->0.
- w_full never asserts.
- w_count stays 0..1.
- w_ptr changes one bit per accepted write.
REQ-037 Reset mid-operation: w_rst=1 at w_count=5 with w_inc=1.
- Next cycle: all outputs 0 and w_addr=0.
REQ-038 Macro build: with FIFO_WR_ALMOST_FULL_EN and AF_THRESHOLD=6, fill from empty.
- w_almost_full rises together with w_count=6.
- w_almost_full falls when w_count drops to 5.
